bfp_frame_scaler: RTL
=====================

# bfp_frame_scaler

Block-floating-point frame normalizer placed directly downstream of the leading-bit magnitude detection in the FFT datapath. It buffers one frame of complex WIDTH-bit stage results and tracks the largest leading-bit index across all real and imaginary parts. It then drains the frame right-shifted by one common amount so that the largest value fits OUT_WIDTH bits. The shift is emitted as a frame exponent for the next butterfly stage and the final scaling.

## Interface
- WIDTH, 23, input sample width (signed, per component)
- OUT_WIDTH, 16, output sample width (signed, per component); 2 ≤ OUT_WIDTH ≤ WIDTH
- FRAME, 64, samples per frame (power of two, ≥ 4)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- din_valid  in  1  input sample valid
- din_ready  out  1  block accepts input this cycle
- din_re  in  WIDTH  signed real part
- din_im  in  WIDTH  signed imaginary part
- dout_valid  out  1  output sample valid
- dout_ready  in  1  downstream accepts output
- dout_re  out  OUT_WIDTH  scaled real part
- dout_im  out  OUT_WIDTH  scaled imaginary part
- dout_last  out  1  high with the FRAME-th output sample
- dout_exp  out  $clog2(WIDTH)  right-shift applied to the current frame; valid whenever dout_valid

## Operation
- Leading-bit index idx(x): the highest bit position in [WIDTH-2:0] that differs from the sign bit x[WIDTH-1]. idx = 0 when no bit differs (x = 0 or x = -1).
- Frame max m: the maximum of idx(din_re) and idx(din_im) over all FRAME accepted samples. m is cleared to 0 at frame start.
- Shift s = max(0, m + 2 - OUT_WIDTH). Each output component is the arithmetic right shift of the stored value by s (floor, no rounding), truncated to its low OUT_WIDTH bits. By construction no overflow occurs.
- Worked example at the defaults: m = 21 gives s = 7; m ≤ 14 gives s = 0.
- FILL state (after reset):
  - din_ready = 1.
  - Each handshake (din_valid & din_ready) writes the sample to buffer address wr_cnt, updates m, and increments wr_cnt.
  - On the FRAME-th handshake: s is latched from the final m, including that last sample, and the state goes to DRAIN.
- DRAIN state:
  - din_ready = 0.
  - Samples are emitted in arrival order from address 0 to FRAME-1; dout_exp = latched s for the whole frame.
  - dout_last is high on the sample at address FRAME-1.
  - When the handshake on that last sample completes, wr_cnt, the read counter and m are cleared and the state returns to FILL.
- The buffer is a single FRAME-deep store of 2·WIDTH bits with registered read, suitable for block RAM.
- No ping-pong: input is stalled for the entire drain.

## Timing
- Reset values: din_ready = 0 during the rst cycle and 1 on the first cycle after; dout_valid = 0, dout_re = 0, dout_im = 0, dout_last = 0, dout_exp = 0. State = FILL, all counters and m cleared.
- Latency: if the last input handshake of a frame occurs in cycle T, din_ready = 0 from T+1 and the first dout_valid is at T+2 (one cycle for the state change, one for the buffer read). This holds regardless of dout_ready.
- Output hold: while dout_valid & !dout_ready, dout_re, dout_im, dout_last and dout_exp hold stable. The read side prefetches or holds so that no sample is skipped or duplicated.
- Throughput: with dout_ready held high, one output per cycle, FRAME consecutive cycles.
- Turnaround: after the dout_last handshake in cycle U, dout_valid = 0 and din_ready = 1 in U+1.
- Gaps in din_valid during FILL are allowed; counters advance only on handshakes.
- rst asserted mid-FILL or mid-DRAIN: the partial frame is discarded and all reset values apply in the next cycle. The next frame is computed only from post-reset samples.

## Test plan
- All-zero frame, dout_ready = 1 → dout_exp = 0; all outputs 0; dout_last on the 64th output; dout_valid exactly 2 cycles after the 64th input.
- One sample re = 2097152 (2^21), others ±3 → m = 21, dout_exp = 7; that sample outputs re = 16384; ±3 outputs 0 / -1 (floor).
- One sample im = -4194304 (min) plus one sample = -1 → idx(-1) = 0 and m = 21, so s = 7; the min sample outputs im = -32768.
- Frame with max |x| = 32767 and one value -32768 → m = 14, s = 0; outputs equal inputs exactly.
- Random frame data with dout_ready toggled pseudo-randomly and din_valid gapped → outputs match the reference model in order with no loss or duplication; din_ready = 0 throughout DRAIN; outputs stable during stalls.
- rst after 10 inputs, then a full frame of max 1000 → dout_exp = 0; the 64 outputs equal only the post-reset samples.

Source files
------------

// File: rtl/bfp_frame_scaler_if.sv
// rtl/bfp_frame_scaler_if.sv - sample-in / scaled-sample-out handshake bundle
// Ports (slave = scaler side):
//    din_valid/din_ready/din_re/din_im       input samples, WIDTH-bit signed
//    dout_valid/dout_ready/dout_re/dout_im   scaled samples, OUT_WIDTH-bit signed
//    dout_last                               final sample of a frame
//    dout_exp                                right shift applied to the frame
interface bfp_frame_scaler_if #(
   parameter int WIDTH     = 23,
   parameter int OUT_WIDTH = 16,
   parameter int EXP_W     = $clog2(WIDTH)
);
   logic                 din_valid;
   logic                 din_ready;
   logic [WIDTH-1:0]     din_re;
   logic [WIDTH-1:0]     din_im;
   logic                 dout_valid;
   logic                 dout_ready;
   logic [OUT_WIDTH-1:0] dout_re;
   logic [OUT_WIDTH-1:0] dout_im;
   logic                 dout_last;
   logic [EXP_W-1:0]     dout_exp;

   modport slave (
      input  din_valid, din_re, din_im, dout_ready,
      output din_ready, dout_valid, dout_re, dout_im, dout_last, dout_exp
   );

   modport master (
      output din_valid, din_re, din_im, dout_ready,
      input  din_ready, dout_valid, dout_re, dout_im, dout_last, dout_exp
   );
endinterface

// File: rtl/bfp_frame_scaler.sv
// rtl/bfp_frame_scaler.sv - block-floating-point frame normalizer
// Ports:
//    clk   rising-edge clock
//    rst   synchronous active-high reset
//    bus   bfp_frame_scaler_if.slave: frame input stream, scaled output stream,
//          dout_last on the final sample, dout_exp = common right shift
module bfp_frame_scaler #(
   parameter int WIDTH     = 23,
   parameter int OUT_WIDTH = 16,
   parameter int FRAME     = 64
) (
   input logic               clk,
   input logic               rst,
   bfp_frame_scaler_if.slave bus
);
   localparam int AW = $clog2(FRAME);
   localparam int EW = $clog2(WIDTH);

   typedef enum logic {FILL, DRAIN} state_t;

   state_t             state, state_nxt;
   logic [AW-1:0]      wr_cnt;
   logic [AW:0]        rd_cnt;        // reads issued this drain, 0..FRAME
   logic [EW-1:0]      m;
   logic [EW-1:0]      s_q;
   logic [2*WIDTH-1:0] mem [FRAME];
   logic [2*WIDTH-1:0] rd_q;
   logic               dout_valid_q;
   logic               dout_last_q;

   logic               din_hs, rd_en, frame_in_done, frame_out_done;
   logic [EW-1:0]      idx_re, idx_im, m_nxt, s_nxt;

   // highest bit below the sign that differs from the sign; 0 for 0 and -1
   function automatic logic [EW-1:0] lead_idx(input logic [WIDTH-1:0] x);
      lead_idx = '0;
      for (int i = 0; i < WIDTH-1; i++) begin
         if (x[i] != x[WIDTH-1]) lead_idx = EW'(i);
      end
   endfunction

   always_comb begin
      din_hs = bus.din_valid && bus.din_ready;
      idx_re = lead_idx(bus.din_re);
      idx_im = lead_idx(bus.din_im);
      m_nxt  = m;
      if (idx_re > m_nxt) m_nxt = idx_re;
      if (idx_im > m_nxt) m_nxt = idx_im;
      // a value with leading index m needs m+2 bits including sign
      s_nxt = '0;
      if (m_nxt > EW'(OUT_WIDTH-2)) s_nxt = m_nxt - EW'(OUT_WIDTH-2);
      frame_in_done  = din_hs && (wr_cnt == AW'(FRAME-1));
      // refill the read register whenever the current output is empty or leaving
      rd_en          = (state == DRAIN) && (rd_cnt != (AW+1)'(FRAME)) &&
                       (!dout_valid_q || bus.dout_ready);
      frame_out_done = dout_valid_q && bus.dout_ready && dout_last_q;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= FILL;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.din_ready = 1'b0;
      case (state)
         FILL: begin
            bus.din_ready = !rst;
            if (frame_in_done) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (frame_out_done) state_nxt = FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (din_hs) mem[wr_cnt] <= {bus.din_re, bus.din_im};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt       <= '0;
         rd_cnt       <= '0;
         m            <= '0;
         s_q          <= '0;
         rd_q         <= '0;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
      end else begin
         if (din_hs) begin
            wr_cnt <= wr_cnt + 1'b1;
            m      <= m_nxt;
            if (frame_in_done) s_q <= s_nxt;
         end
         if (rd_en) begin
            rd_q         <= mem[rd_cnt[AW-1:0]];
            rd_cnt       <= rd_cnt + 1'b1;
            dout_valid_q <= 1'b1;
            dout_last_q  <= (rd_cnt == (AW+1)'(FRAME-1));
         end else if (bus.dout_ready) begin
            dout_valid_q <= 1'b0;
         end
         if (frame_out_done) begin
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            m           <= '0;
            dout_last_q <= 1'b0;
         end
      end
   end

   assign bus.dout_valid = dout_valid_q;
   assign bus.dout_last  = dout_last_q;
   assign bus.dout_exp   = s_q;
   assign bus.dout_re    = OUT_WIDTH'($signed(rd_q[2*WIDTH-1:WIDTH]) >>> s_q);
   assign bus.dout_im    = OUT_WIDTH'($signed(rd_q[WIDTH-1:0]) >>> s_q);
endmodule
